// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// The stall/flush counters exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if #(
  parameter int PERF_W = 16
);

  if (PERF_W < 1) begin : g_perf_w_chk
    $error("hazard_ctrl_if: PERF_W must be at least 1");
  end

  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_valid;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       branch_taken;
  logic       mem_busy;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_write;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_mem_read, ex_rd, branch_taken, mem_busy,
`ifdef HAZARD_PERF_EN
    input  stall_cnt, flush_cnt,
`endif
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, state_o
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_mem_read, ex_rd, branch_taken, mem_busy,
`ifdef HAZARD_PERF_EN
    output stall_cnt, flush_cnt,
`endif
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, state_o
  );

endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, taken-branch flush and data-memory freeze control.
// Define HAZARD_PERF_EN to add saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int PERF_W            = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LSTALL    = 2'd1;
  localparam logic [1:0] ST_FLUSH     = 2'd2;
  localparam logic [1:0] ST_FREEZE    = 2'd3;
  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 3 || PERF_W < 1) begin : g_param_chk
    $error("hazard_ctrl: LOAD_STALL_CYCLES must be 1..3 and PERF_W at least 1");
  end

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic [1:0] shadow_state_q;
  logic [1:0] shadow_state_d;
  logic [1:0] shadow_cnt_q;
  logic [1:0] shadow_cnt_d;
  logic [1:0] eff_state_s;
  logic [1:0] eff_cnt_s;
  logic       rs1_hit_s;
  logic       rs2_hit_s;
  logic       hazard_s;
  logic       pc_write_s;
  logic       if_id_write_s;
  logic       if_id_flush_s;
  logic       id_ex_flush_s;
  logic       ex_mem_write_s;
  logic [1:0] state_o_s;

  // Load-use match; x0 never carries a dependency
  always_comb begin
    rs1_hit_s = bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd);
    rs2_hit_s = bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd);
    hazard_s  = bus.id_valid & bus.ex_valid & bus.ex_mem_read &
                (bus.ex_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);
  end

  // On the first non-busy FREEZE cycle act as the state saved on entry
  always_comb begin
    if (state_q == ST_FREEZE) begin
      eff_state_s = shadow_state_q;
      eff_cnt_s   = shadow_cnt_q;
    end else begin
      eff_state_s = state_q;
      eff_cnt_s   = cnt_q;
    end
  end

  // Next state and pipeline enables; priority is mem_busy, branch, hazard
  always_comb begin
    state_d        = ST_RUN;
    cnt_d          = 2'd0;
    shadow_state_d = shadow_state_q;
    shadow_cnt_d   = shadow_cnt_q;
    pc_write_s     = 1'b1;
    if_id_write_s  = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_write_s = 1'b1;
    state_o_s      = state_q;
    if (!reset_n) begin
      shadow_state_d = ST_RUN;
      shadow_cnt_d   = 2'd0;
      state_o_s      = ST_RUN;
    end else if (bus.mem_busy) begin
      pc_write_s     = 1'b0;
      if_id_write_s  = 1'b0;
      ex_mem_write_s = 1'b0;
      state_d        = ST_FREEZE;
      cnt_d          = cnt_q;
      if (state_q != ST_FREEZE) begin
        shadow_state_d = state_q;
        shadow_cnt_d   = cnt_q;
      end else begin
        shadow_state_d = shadow_state_q;
        shadow_cnt_d   = shadow_cnt_q;
      end
    end else if (bus.branch_taken) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
      state_d       = ST_FLUSH;
      cnt_d         = 2'd0;
    end else begin
      case (eff_state_s)
        ST_RUN: begin
          if (hazard_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            id_ex_flush_s = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = ST_LSTALL;
              cnt_d   = STALL_RELOAD;
            end else begin
              state_d = ST_RUN;
              cnt_d   = 2'd0;
            end
          end else begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
          end
        end
        ST_LSTALL: begin
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
          id_ex_flush_s = 1'b1;
          if (eff_cnt_s <= 2'd1) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
          end else begin
            state_d = ST_LSTALL;
            cnt_d   = eff_cnt_s - 2'd1;
          end
        end
        ST_FLUSH: begin
          if_id_flush_s = 1'b1;
          state_d       = ST_RUN;
          cnt_d         = 2'd0;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // State, stall counter and freeze shadow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      cnt_q          <= 2'd0;
      shadow_state_q <= ST_RUN;
      shadow_cnt_q   <= 2'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_state_q <= shadow_state_d;
      shadow_cnt_q   <= shadow_cnt_d;
    end
  end

  assign bus.pc_write     = pc_write_s;
  assign bus.if_id_write  = if_id_write_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_flush  = id_ex_flush_s;
  assign bus.ex_mem_write = ex_mem_write_s;
  assign bus.state_o      = state_o_s;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;
  logic              stall_evt_s;
  logic              flush_evt_s;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    if (en && (v != {PERF_W{1'b1}})) begin
      sat_inc = v + PERF_W'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  // Enables are all low while frozen, so neither event fires then
  always_comb begin
    stall_evt_s = id_ex_flush_s & ~if_id_flush_s;
    flush_evt_s = if_id_flush_s;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= {PERF_W{1'b0}};
      flush_cnt_q <= {PERF_W{1'b0}};
    end else begin
      stall_cnt_q <= sat_inc(stall_cnt_q, stall_evt_s);
      flush_cnt_q <= sat_inc(flush_cnt_q, flush_evt_s);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 load-stall cycles) share stimulus and
// are compared every cycle against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int PMAX = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.PERF_W(2)) b1 ();
  hazard_ctrl_if #(.PERF_W(2)) b3 ();

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .PERF_W(2)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .PERF_W(2)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));

  int total = 0;
  int bad   = 0;

  logic       c_rst, c_idv, c_u1, c_u2, c_exv, c_exmr, c_br, c_busy;
  logic [4:0] c_rs1, c_rs2, c_exrd;

  // model: remaining stall cycles, pending flush cycle, frozen last cycle
  int         rem     [2];
  bit         flushp  [2];
  bit         frozen  [2];
  int         stalls  [2];
  int         flushes [2];
  logic [6:0] exp_v   [2];
  int         exp_stall [2];
  int         exp_flush [2];

  function automatic logic [6:0] obs(input int k);
    if (k == 0)
      return {b1.pc_write, b1.if_id_write, b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_write, b1.state_o};
    else
      return {b3.pc_write, b3.if_id_write, b3.if_id_flush, b3.id_ex_flush, b3.ex_mem_write, b3.state_o};
  endfunction

  task automatic model_step(input int k);
    int lsc;
    bit haz;
    logic [1:0] st;
    logic [4:0] en;
    lsc = (k == 0) ? 1 : 3;
    haz = c_idv && c_exv && c_exmr && (c_exrd != 5'd0) &&
          ((c_u1 && c_rs1 == c_exrd) || (c_u2 && c_rs2 == c_exrd));
    st  = frozen[k] ? 2'd3 : flushp[k] ? 2'd2 : (rem[k] > 0) ? 2'd1 : 2'd0;
    exp_stall[k] = stalls[k];
    exp_flush[k] = flushes[k];
    if (!c_rst) begin
      en = 5'b11001; st = 2'd0;
      rem[k] = 0; flushp[k] = 0; frozen[k] = 0; stalls[k] = 0; flushes[k] = 0;
    end else if (c_busy) begin
      en = 5'b00000; frozen[k] = 1;
    end else begin
      frozen[k] = 0;
      if (c_br) begin
        en = 5'b11111; flushp[k] = 1; rem[k] = 0;
      end else if (flushp[k]) begin
        en = 5'b11101; flushp[k] = 0;
      end else if (rem[k] > 0) begin
        en = 5'b00011; rem[k] = rem[k] - 1;
      end else if (haz) begin
        en = 5'b00011; rem[k] = lsc - 1;
      end else begin
        en = 5'b11001;
      end
      if (en == 5'b00011 && stalls[k] < PMAX) stalls[k] = stalls[k] + 1;
      if (en[2] && flushes[k] < PMAX) flushes[k] = flushes[k] + 1;
    end
    exp_v[k] = {en, st};
  endtask

  task automatic apply(input logic rst, idv, input logic [4:0] rs1, rs2, input logic u1, u2, exv, exmr,
                       input logic [4:0] exrd, input logic br, busy);
    @(posedge clk);
    #1;
    c_rst = rst; c_idv = idv; c_rs1 = rs1; c_rs2 = rs2; c_u1 = u1; c_u2 = u2;
    c_exv = exv; c_exmr = exmr; c_exrd = exrd; c_br = br; c_busy = busy;
    reset_n = rst;
    b1.id_valid = idv; b1.id_rs1 = rs1; b1.id_rs2 = rs2; b1.id_uses_rs1 = u1; b1.id_uses_rs2 = u2;
    b1.ex_valid = exv; b1.ex_mem_read = exmr; b1.ex_rd = exrd; b1.branch_taken = br; b1.mem_busy = busy;
    b3.id_valid = idv; b3.id_rs1 = rs1; b3.id_rs2 = rs2; b3.id_uses_rs1 = u1; b3.id_uses_rs2 = u2;
    b3.ex_valid = exv; b3.ex_mem_read = exmr; b3.ex_rd = exrd; b3.branch_taken = br; b3.mem_busy = busy;
    #2;
    for (int k = 0; k < 2; k++) model_step(k);
  endtask

  // kind: 0 = lw x5 in EX / add x5 in ID, 1 = EX bubble, 2 = EX bubble with mem_busy
  task automatic step_kind(input logic rst, input int kind, input logic br);
    case (kind)
      0:       apply(rst, 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, br, 1'b0);
      1:       apply(rst, 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, br, 1'b0);
      default: apply(rst, 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, br, 1'b1);
    endcase
  endtask

  task automatic test_reset();
    step_kind(1'b0, 2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 7'b1100100) begin
        bad++; $display("FAIL reset_during dut%0d: got=%b want=%b", k, obs(k), 7'b1100100);
      end
    end
    step_kind(1'b1, 1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== exp_v[k]) begin
        bad++; $display("FAIL reset_after dut%0d: got=%b want=%b", k, obs(k), exp_v[k]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [1:0] seq3 [4];
    logic       pc1  [4];
    seq3 = '{2'd0, 2'd1, 2'd1, 2'd0};
    pc1  = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step_kind(1'b1, (i == 0) ? 0 : 1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_v[k]) begin
          bad++; $display("FAIL load_use dut%0d cyc%0d: got=%b want=%b", k, i, obs(k), exp_v[k]);
        end
      end
      total++;
      if (b3.state_o !== seq3[i]) begin
        bad++; $display("FAIL load_use_state3 cyc%0d: got=%0d want=%0d", i, b3.state_o, seq3[i]);
      end
      total++;
      if (b1.pc_write !== pc1[i]) begin
        bad++; $display("FAIL load_use_pc1 cyc%0d: got=%b want=%b", i, b1.pc_write, pc1[i]);
      end
    end
  endtask

  task automatic test_no_hazard();
    // lui x5, ex_rd=x0, EX not a load, EX bubble, ID bubble
    apply(1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      case (p)
        0:       ;
        1:       apply(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        2:       apply(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
        3:       apply(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        default: apply(1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
      endcase
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== 7'b1100100 || obs(k) !== exp_v[k]) begin
          bad++; $display("FAIL no_hazard dut%0d pat%0d: got=%b want=%b", k, p, obs(k), exp_v[k]);
        end
      end
    end
    // rs2-only match does stall
    apply(1'b1, 1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step_kind(1'b1, 1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_v[k]) begin
          bad++; $display("FAIL rs2_hazard dut%0d cyc%0d: got=%b want=%b", k, i, obs(k), exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_branch_preempt();
    int         kind [5];
    logic       br   [5];
    logic [1:0] st3  [5];
    logic       iff3 [5];
    kind = '{0, 0, 1, 1, 1};
    br   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    st3  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    iff3 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step_kind(1'b1, kind[i], br[i]);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_v[k]) begin
          bad++; $display("FAIL branch dut%0d cyc%0d: got=%b want=%b", k, i, obs(k), exp_v[k]);
        end
      end
      total++;
      if (b3.state_o !== st3[i] || b3.if_id_flush !== iff3[i]) begin
        bad++; $display("FAIL branch_seq3 cyc%0d: got=%0d/%b want=%0d/%b", i, b3.state_o, b3.if_id_flush, st3[i], iff3[i]);
      end
    end
  endtask

  task automatic test_freeze();
    int   kind [8];
    logic pc3  [8];
    logic em3  [8];
    int   kr   [5];
    logic rr   [5];
    kind = '{0, 1, 2, 2, 2, 2, 1, 1};
    pc3  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    em3  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step_kind(1'b1, kind[i], 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_v[k]) begin
          bad++; $display("FAIL freeze dut%0d cyc%0d: got=%b want=%b", k, i, obs(k), exp_v[k]);
        end
      end
      total++;
      if (b3.pc_write !== pc3[i] || b3.ex_mem_write !== em3[i]) begin
        bad++; $display("FAIL freeze_seq3 cyc%0d: got=%b%b want=%b%b", i, b3.pc_write, b3.ex_mem_write, pc3[i], em3[i]);
      end
    end
    // reset in the middle of a frozen stall leaves nothing behind
    kr = '{0, 2, 2, 1, 1};
    rr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step_kind(rr[i], kr[i], 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_v[k]) begin
          bad++; $display("FAIL freeze_reset dut%0d cyc%0d: got=%b want=%b", k, i, obs(k), exp_v[k]);
        end
      end
      if (i >= 3) begin
        total++;
        if (b3.pc_write !== 1'b1 || b3.state_o !== 2'd0) begin
          bad++; $display("FAIL freeze_reset_run cyc%0d: got pc=%b st=%0d want pc=1 st=0", i, b3.pc_write, b3.state_o);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 49) != 0), 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_v[k]) begin
          bad++; $display("FAIL random dut%0d cyc%0d: got=%b want=%b", k, i, obs(k), exp_v[k]);
        end
      end
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    step_kind(1'b0, 1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step_kind(1'b1, (i < 5) ? 0 : 1, (i == 6));
      total++;
      if (b1.stall_cnt !== 2'(exp_stall[0]) || b3.stall_cnt !== 2'(exp_stall[1]) ||
          b1.flush_cnt !== 2'(exp_flush[0]) || b3.flush_cnt !== 2'(exp_flush[1])) begin
        bad++; $display("FAIL perf cyc%0d: got s=%0d/%0d f=%0d/%0d want s=%0d/%0d f=%0d/%0d", i,
                        b1.stall_cnt, b3.stall_cnt, b1.flush_cnt, b3.flush_cnt,
                        exp_stall[0], exp_stall[1], exp_flush[0], exp_flush[1]);
      end
    end
    total++;
    if (b1.stall_cnt !== 2'd3) begin
      bad++; $display("FAIL perf_sat: got=%0d want=3", b1.stall_cnt);
    end
    step_kind(1'b0, 1, 1'b0);
    step_kind(1'b1, 1, 1'b0);
    total++;
    if (b1.stall_cnt !== 2'd0 || b1.flush_cnt !== 2'd0) begin
      bad++; $display("FAIL perf_reset: got s=%0d f=%0d want 0 0", b1.stall_cnt, b1.flush_cnt);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; flushp[k] = 0; frozen[k] = 0; stalls[k] = 0; flushes[k] = 0;
    end
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_preempt();
    test_freeze();
    test_random();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYCLES, default 1: bubble cycles inserted per load-use hazard; legal range 1..3.
REQ-002 SHALL have parameter PERF_W, default 16: width of each performance counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port id_valid, input, 1: the IF/ID register holds a real instruction.
REQ-006 SHALL have ports id_rs1 and id_rs2, input, 5 each: decode-stage source register indices.
REQ-007 SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1 each: the decoded encoding reads that source (e.g. U_TYPE reads neither; I_TYPE reads rs1 only).
REQ-008 SHALL have port ex_valid, input, 1: the ID/EX register holds a real instruction.
REQ-009 SHALL have port ex_mem_read, input, 1: the EX-stage instruction is a load.
REQ-010 SHALL have port ex_rd, input, 5: EX-stage destination register.
REQ-011 SHALL have port branch_taken, input, 1: EX resolved a taken branch or jump this cycle.
REQ-012 SHALL have port mem_busy, input, 1: data memory is not ready; the whole pipeline freezes.
REQ-013 SHALL have outputs pc_write and if_id_write, 1 each: enables for the PC and IF/ID registers.
REQ-014 SHALL have outputs if_id_flush and id_ex_flush, 1 each: insert a bubble into that register.
REQ-015 SHALL have output ex_mem_write, 1: enable for EX/MEM and later registers.
REQ-016 SHALL have output state_o, 2: current FSM state, encoded RUN=0, LSTALL=1, FLUSH=2, FREEZE=3.

Function
REQ-017 SHALL declare a hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-018 SHALL, in RUN with no event, drive pc_write=if_id_write=ex_mem_write=1 and both flush outputs 0.
REQ-019 SHALL, in RUN on a hazard, in the same cycle drive pc_write=0, if_id_write=0 and id_ex_flush=1.
REQ-020 SHALL, on that hazard with LOAD_STALL_CYCLES>1, enter LSTALL and load a down-counter with LOAD_STALL_CYCLES-1; with LOAD_STALL_CYCLES=1, remain in RUN.
REQ-021 SHALL, in LSTALL, hold pc_write=0, if_id_write=0 and id_ex_flush=1, decrement the counter each cycle, and return to RUN in the cycle after it reads 1.
REQ-022 SHALL, on branch_taken, in the same cycle drive if_id_flush=1, id_ex_flush=1 and pc_write=1, then spend exactly one cycle in FLUSH with if_id_flush=1 before returning to RUN.
REQ-023 SHALL let branch_taken preempt LSTALL: the counter clears and the stalled instruction is discarded.
REQ-024 SHALL, whenever mem_busy=1, drive pc_write=if_id_write=ex_mem_write=0 and both flushes 0, and enter FREEZE.
REQ-025 SHALL hold the prior state and counter in a shadow register during FREEZE and resume them on the first cycle with mem_busy=0.
REQ-026 SHALL apply event priority mem_busy > branch_taken > hazard; a hazard coinciding with branch_taken is ignored.
REQ-027 SHALL treat x0 (ex_rd=0) as never producing a hazard.

Reset
REQ-028 SHALL, while reset_n=0 at a clock edge, set state to RUN, clear the counter and shadow register, and clear any performance counters.
REQ-029 SHALL drive, during and immediately after reset: pc_write=if_id_write=ex_mem_write=1, flushes=0, state_o=0.
REQ-030 SHALL let a reset asserted mid-LSTALL or mid-FREEZE abort that state with no residual stall.

Configuration
REQ-031 SHALL, with HAZARD_PERF_EN defined, add outputs stall_cnt and flush_cnt, PERF_W each, counting LSTALL/hazard stall cycles and flush cycles respectively.
REQ-032 SHALL make those counters saturate at all-ones and not count during FREEZE.
REQ-033 SHALL, without HAZARD_PERF_EN, omit both ports and their logic entirely; all other behaviour is identical.

Verification
REQ-034 SHALL cover: LOAD_STALL_CYCLES=1, EX lw rd=5, ID add rs1=5 -> one cycle of pc_write=0 and id_ex_flush=1, then RUN.
REQ-035 SHALL cover: LOAD_STALL_CYCLES=3, same hazard -> exactly 3 stall cycles; state_o sequence 0,1,1,0.
REQ-036 SHALL cover: ID lui (no sources, rd=5 match) or ex_rd=0 -> no stall.
REQ-037 SHALL cover: branch_taken in cycle 2 of a 3-cycle LSTALL -> flush asserted, FLUSH for 1 cycle, RUN; no further stall.
REQ-038 SHALL cover: mem_busy held 4 cycles during LSTALL with counter=1 -> all enables 0 for 4 cycles, then 1 LSTALL cycle, then RUN.
REQ-039 SHALL cover: HAZARD_PERF_EN with PERF_W=2 and 5 hazard stalls -> stall_cnt saturates at 3; reset_n low for 1 cycle -> 0.
